// File: rtl/wb_forward_pipe.sv
// Write-back forwarding pipe: DEPTH in-flight results, youngest-match operand bypass.
// Latency: an accepted entry with its data ready retires on rf_we after DEPTH shift cycles.
// Backpressure: issue_ready drops on a stalled tail (pending load in oldest stage) or an operand hazard.
//
// Optional feature macro: RVIBE_WB_FORWARD_EN
//   defined   - ready in-flight results are bypassed onto rs_data
//   undefined - any in-flight match stalls issue until that entry retires; rs_data = rf_rdata
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   issue_valid/issue_ready      producer handshake for a write-back entry
//   issue_we/rd/data/data_rdy    entry payload; data_rdy=0 marks a load with late data
//   ld_valid, ld_data            late load data for the single pending entry
//   rs_addr, rs_used, rf_rdata   per-read-port address, enable, raw register-file data
//   rs_data                      per-read-port forwarded operand
//   rf_we, rf_waddr, rf_wdata    register-file write port (oldest stage retiring)
//   occupancy                    number of valid entries in the pipe
module wb_forward_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int NRP   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic                  issue_we,
  input  logic [4:0]            issue_rd,
  input  logic [XLEN-1:0]       issue_data,
  input  logic                  issue_data_rdy,
  input  logic                  ld_valid,
  input  logic [XLEN-1:0]       ld_data,
  input  logic [NRP*5-1:0]      rs_addr,
  input  logic [NRP-1:0]        rs_used,
  input  logic [NRP*XLEN-1:0]   rf_rdata,
  output logic [NRP*XLEN-1:0]   rs_data,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [3:0]            occupancy
);

  // Stage 0 is the youngest entry, stage DEPTH-1 the oldest.
  logic [DEPTH-1:0]            v_q, we_q, rdy_q;
  logic [DEPTH-1:0][4:0]       rd_q;
  logic [DEPTH-1:0][XLEN-1:0]  data_q;

  logic [DEPTH-1:0]            v_d, we_d, rdy_d;
  logic [DEPTH-1:0][4:0]       rd_d;
  logic [DEPTH-1:0][XLEN-1:0]  data_d;

  logic [DEPTH-1:0] pend_q;   // valid entry still waiting for load data
  logic [DEPTH-1:0] pend_d;   // old pending flag tracked to its post-shift slot
  logic             shift;
  logic             hazard;
  logic             port_pend;
  logic             accept;

  assign pend_q = v_q & ~rdy_q;

  // The whole pipe freezes only when the oldest entry cannot retire yet.
  assign shift       = ~(v_q[DEPTH-1] & ~rdy_q[DEPTH-1]);
  assign issue_ready = shift & ~hazard;
  assign accept      = issue_valid & issue_ready;

  // Operand lookup. Scanning oldest to youngest lets the last hit (youngest) win.
  always_comb begin
    // A second outstanding load is refused so ld_valid always has one unambiguous target.
    hazard    = ~issue_data_rdy & (|pend_q);
    rs_data   = rf_rdata;
    port_pend = 1'b0;
    for (int i = 0; i < NRP; i++) begin
      port_pend = 1'b0;
      for (int s = DEPTH-1; s >= 0; s--) begin
        if (rs_used[i] && v_q[s] && we_q[s] &&
            (rd_q[s] == rs_addr[i*5 +: 5]) && (rd_q[s] != 5'd0)) begin
`ifdef RVIBE_WB_FORWARD_EN
          port_pend = ~rdy_q[s];
          if (rdy_q[s]) rs_data[i*XLEN +: XLEN] = data_q[s];
          else          rs_data[i*XLEN +: XLEN] = rf_rdata[i*XLEN +: XLEN];
`else
          port_pend = 1'b1;
`endif
        end
      end
      hazard = hazard | port_pend;
    end
  end

  // Next-state: optional shift, then late load data lands wherever the old pending entry ends up.
  always_comb begin
    v_d    = v_q;
    we_d   = we_q;
    rdy_d  = rdy_q;
    rd_d   = rd_q;
    data_d = data_q;
    pend_d = pend_q;
    if (shift) begin
      for (int s = DEPTH-1; s > 0; s--) begin
        v_d[s]    = v_q[s-1];
        we_d[s]   = we_q[s-1];
        rdy_d[s]  = rdy_q[s-1];
        rd_d[s]   = rd_q[s-1];
        data_d[s] = data_q[s-1];
        pend_d[s] = pend_q[s-1];
      end
      v_d[0]    = accept;
      we_d[0]   = accept & issue_we;
      rd_d[0]   = accept ? issue_rd : 5'd0;
      rdy_d[0]  = ~accept | issue_data_rdy;
      data_d[0] = (accept && issue_data_rdy) ? issue_data : '0;
      // A load accepted this cycle is never the target of this cycle's ld_valid.
      pend_d[0] = 1'b0;
    end
    if (ld_valid) begin
      for (int s = 0; s < DEPTH; s++) begin
        if (pend_d[s]) begin
          data_d[s] = ld_data;
          rdy_d[s]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q    <= '0;
      we_q   <= '0;
      rdy_q  <= '1;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      we_q   <= we_d;
      rdy_q  <= rdy_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  assign rf_we    = shift & v_q[DEPTH-1] & we_q[DEPTH-1] & (rd_q[DEPTH-1] != 5'd0);
  assign rf_waddr = rd_q[DEPTH-1];
  assign rf_wdata = data_q[DEPTH-1];

  always_comb begin
    occupancy = 4'd0;
    for (int s = 0; s < DEPTH; s++) occupancy = occupancy + {3'b000, v_q[s]};
  end

endmodule

// File: tb/tb_wb_forward_pipe.sv
// Bench for wb_forward_pipe: directed scenarios plus random traffic against a queue-based model.
module tb_wb_forward_pipe;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int NRP   = 2;
`ifdef RVIBE_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                 clk;
  logic                 rst_n;
  logic                 issue_valid;
  logic                 issue_ready;
  logic                 issue_we;
  logic [4:0]           issue_rd;
  logic [XLEN-1:0]      issue_data;
  logic                 issue_data_rdy;
  logic                 ld_valid;
  logic [XLEN-1:0]      ld_data;
  logic [NRP*5-1:0]     rs_addr;
  logic [NRP-1:0]       rs_used;
  logic [NRP*XLEN-1:0]  rf_rdata;
  logic [NRP*XLEN-1:0]  rs_data;
  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic [3:0]           occupancy;

  wb_forward_pipe #(.XLEN(XLEN), .DEPTH(DEPTH), .NRP(NRP)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_we(issue_we), .issue_rd(issue_rd), .issue_data(issue_data),
    .issue_data_rdy(issue_data_rdy),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .rs_addr(rs_addr), .rs_used(rs_used), .rf_rdata(rf_rdata),
    .rs_data(rs_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of in-flight results, element 0 youngest, always DEPTH long.
  typedef struct {
    bit        v;
    bit        we;
    bit [4:0]  rd;
    bit [31:0] data;
    bit        rdy;
  } ent_t;

  ent_t pq[$];
  int   checks = 0;
  int   errors = 0;

  // Model expectations for the current cycle.
  bit        m_hold, m_pend, e_ready, e_we;
  bit [31:0] e_rs [NRP];
  bit [4:0]  e_waddr;
  bit [31:0] e_wdata;
  int        e_occ;

  // Observed DUT outputs, sampled mid low-phase.
  logic        obs_ready, obs_we;
  logic [4:0]  obs_waddr;
  logic [31:0] obs_wdata, obs_rf0, obs_rf1, obs_rs0, obs_rs1;
  logic [3:0]  obs_occ;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t bubble();
    ent_t b;
    b.v = 0; b.we = 0; b.rd = 0; b.data = 0; b.rdy = 1;
    return b;
  endfunction

  task automatic model_reset();
    pq.delete();
    for (int s = 0; s < DEPTH; s++) pq.push_back(bubble());
  endtask

  task automatic model_eval();
    bit haz;
    ent_t last;
    m_pend = 0;
    e_occ  = 0;
    foreach (pq[s]) begin
      if (pq[s].v) e_occ++;
      if (pq[s].v && !pq[s].rdy) m_pend = 1;
    end
    last   = pq[DEPTH-1];
    m_hold = last.v && !last.rdy;
    haz    = !issue_data_rdy && m_pend;
    for (int p = 0; p < NRP; p++) begin
      bit found;
      found   = 0;
      e_rs[p] = rf_rdata[p*XLEN +: XLEN];
      if (rs_used[p] && rs_addr[p*5 +: 5] != 0) begin
        for (int s = 0; s < DEPTH && !found; s++) begin
          if (pq[s].v && pq[s].we && pq[s].rd == rs_addr[p*5 +: 5]) begin
            found = 1;
            if (!FWD || !pq[s].rdy) haz = 1;
            else e_rs[p] = pq[s].data;
          end
        end
      end
    end
    e_ready = !m_hold && !haz;
    e_we    = !m_hold && last.v && last.we && last.rd != 0;
    e_waddr = last.rd;
    e_wdata = last.data;
  endtask

  task automatic model_update();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (!m_hold) begin
        ent_t n;
        void'(pq.pop_back());
        if (issue_valid && e_ready) begin
          n.v = 1; n.we = issue_we; n.rd = issue_rd; n.rdy = issue_data_rdy;
          n.data = issue_data_rdy ? issue_data : 32'h0;
          pq.push_front(n);
        end else begin
          pq.push_front(bubble());
        end
      end
      // Only a load pending before this edge can absorb ld_valid.
      if (ld_valid && m_pend) begin
        foreach (pq[s]) begin
          if (pq[s].v && !pq[s].rdy) begin
            ent_t t;
            t = pq[s]; t.data = ld_data; t.rdy = 1; pq[s] = t;
          end
        end
      end
    end
  endtask

  task automatic drive(input bit iv, input bit iwe, input bit [4:0] ird, input bit [31:0] idat,
                       input bit idr, input bit lv, input bit [31:0] ld,
                       input bit [4:0] a0, input bit u0, input bit [4:0] a1, input bit u1);
    issue_valid = iv; issue_we = iwe; issue_rd = ird; issue_data = idat; issue_data_rdy = idr;
    ld_valid = lv; ld_data = ld;
    rs_addr = {a1, a0}; rs_used = {u1, u0};
    rf_rdata = {$urandom, $urandom};
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock: sample and check mid low-phase, advance model at the edge, return at negedge.
  task automatic cycle();
    #1;
    model_eval();
    obs_ready = issue_ready; obs_we = rf_we; obs_waddr = rf_waddr; obs_wdata = rf_wdata;
    obs_rs0 = rs_data[31:0]; obs_rs1 = rs_data[63:32]; obs_occ = occupancy;
    obs_rf0 = rf_rdata[31:0]; obs_rf1 = rf_rdata[63:32];
    if (rst_n) begin
      chk("m_ready", {31'b0, obs_ready}, {31'b0, e_ready});
      chk("m_rs0", obs_rs0, e_rs[0]);
      chk("m_rs1", obs_rs1, e_rs[1]);
      chk("m_rf_we", {31'b0, obs_we}, {31'b0, e_we});
      chk("m_occ", {28'b0, obs_occ}, e_occ[31:0]);
      if (e_we) begin
        chk("m_waddr", {27'b0, obs_waddr}, {27'b0, e_waddr});
        chk("m_wdata", obs_wdata, e_wdata);
      end
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    @(negedge clk);
    cycle();
    cycle();
    rst_n = 1'b1;

    // Post-reset state.
    idle(); rs_used = 2'b11; rs_addr = {5'd3, 5'd1};
    cycle();
    chk("rst_occ", {28'b0, obs_occ}, 32'd0);
    chk("rst_rf_we", {31'b0, obs_we}, 32'd0);
    chk("rst_ready", {31'b0, obs_ready}, 32'd1);
    chk("rst_rs0", obs_rs0, obs_rf0);

    // Issue x5=0x11 then read x5 for three cycles.
    drive(1, 1, 5, 32'h11, 1, 0, 0, 0, 0, 0, 0); cycle();
    chk("x5_issue_ready", {31'b0, obs_ready}, 32'd1);
    drive(0, 0, 0, 0, 1, 0, 0, 5, 1, 0, 0); cycle();
    chk("x5_b_ready", {31'b0, obs_ready}, FWD ? 32'd1 : 32'd0);
    chk("x5_b_rs0", obs_rs0, FWD ? 32'h11 : obs_rf0);
    drive(0, 0, 0, 0, 1, 0, 0, 5, 1, 0, 0); cycle();
    chk("x5_c_ready", {31'b0, obs_ready}, FWD ? 32'd1 : 32'd0);
    chk("x5_c_rf_we", {31'b0, obs_we}, 32'd1);
    chk("x5_c_waddr", {27'b0, obs_waddr}, 32'd5);
    chk("x5_c_wdata", obs_wdata, 32'h11);
    drive(0, 0, 0, 0, 1, 0, 0, 5, 1, 0, 0); cycle();
    chk("x5_d_ready", {31'b0, obs_ready}, 32'd1);
    chk("x5_d_rs0", obs_rs0, obs_rf0);

    // Youngest match wins.
    drive(1, 1, 6, 32'hA, 1, 0, 0, 0, 0, 0, 0); cycle();
    drive(1, 1, 6, 32'hB, 1, 0, 0, 0, 0, 0, 0); cycle();
    chk("x6_second_ready", {31'b0, obs_ready}, 32'd1);
    drive(0, 0, 0, 0, 1, 0, 0, 6, 1, 0, 0); cycle();
    chk("x6_rs0", obs_rs0, FWD ? 32'hB : obs_rf0);
    chk("x6_ready", {31'b0, obs_ready}, FWD ? 32'd1 : 32'd0);
    idle(); cycle(); cycle();

    // Pending load: refusal of a second load, tail hold, late data.
    drive(1, 1, 7, 32'h0, 0, 0, 0, 0, 0, 0, 0); cycle();
    chk("ld_issue_ready", {31'b0, obs_ready}, 32'd1);
    drive(1, 1, 8, 32'h0, 0, 0, 0, 0, 0, 0, 0); cycle();
    chk("ld_second_refused", {31'b0, obs_ready}, 32'd0);
    drive(0, 0, 0, 0, 1, 0, 0, 7, 1, 0, 0); cycle();
    chk("ld_hold_ready", {31'b0, obs_ready}, 32'd0);
    chk("ld_hold_occ", {28'b0, obs_occ}, 32'd1);
    chk("ld_hold_rf_we", {31'b0, obs_we}, 32'd0);
    drive(0, 0, 0, 0, 1, 1, 32'h55, 7, 1, 0, 0); cycle();
    chk("ld_same_cycle_rs0", obs_rs0, obs_rf0);
    chk("ld_same_cycle_occ", {28'b0, obs_occ}, 32'd1);
    drive(0, 0, 0, 0, 1, 0, 0, 7, 1, 0, 0); cycle();
    chk("ld_next_rs0", obs_rs0, FWD ? 32'h55 : obs_rf0);
    chk("ld_next_ready", {31'b0, obs_ready}, FWD ? 32'd1 : 32'd0);
    chk("ld_retire_we", {31'b0, obs_we}, 32'd1);
    chk("ld_retire_waddr", {27'b0, obs_waddr}, 32'd7);
    chk("ld_retire_wdata", obs_wdata, 32'h55);
    idle(); cycle();

    // x0 never forwards and never writes.
    drive(1, 1, 0, 32'hFF, 1, 0, 0, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1); cycle();
    chk("x0_rs1", obs_rs1, obs_rf1);
    chk("x0_ready", {31'b0, obs_ready}, 32'd1);
    idle(); cycle();
    chk("x0_rf_we", {31'b0, obs_we}, 32'd0);
    chk("x0_occ", {28'b0, obs_occ}, 32'd1);
    idle(); cycle();

    // Reset mid-operation drops a pending load.
    drive(1, 1, 9, 32'h0, 0, 0, 0, 0, 0, 0, 0); cycle();
    rst_n = 1'b0; idle(); cycle();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 1, 1, 32'h77, 9, 1, 0, 0); cycle();
    chk("mid_rst_occ", {28'b0, obs_occ}, 32'd0);
    chk("mid_rst_ready", {31'b0, obs_ready}, 32'd1);
    drive(0, 0, 0, 0, 1, 0, 0, 9, 1, 0, 0); cycle();
    chk("mid_rst_rs0", obs_rs0, obs_rf0);
    chk("mid_rst_occ2", {28'b0, obs_occ}, 32'd0);

    // Random traffic on a narrow register range to provoke matches.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(99) < 60, $urandom_range(9) != 0, 5'($urandom_range(7)), $urandom,
            $urandom_range(99) < 75, $urandom_range(99) < 25, $urandom,
            5'($urandom_range(7)), $urandom_range(1) == 1, 5'($urandom_range(7)),
            $urandom_range(1) == 1);
      rst_n = ($urandom_range(199) != 0);
      cycle();
    end
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_forward_pipe.md
WB_FORWARD_PIPE -- requirements
Module: wb_forward_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter DEPTH, default 2, number of in-flight write-back stages (1..8).
REQ-003 SHALL have parameter NRP, default 2, number of register read ports (1..4).
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port issue_valid  input  1  producer presents a write-back entry.
REQ-007 SHALL have port issue_ready  output  1  entry accepted this cycle when high with issue_valid.
REQ-008 SHALL have ports issue_we (1), issue_rd (5), issue_data (XLEN), issue_data_rdy (1), all inputs; issue_data_rdy=0 marks a load whose data arrives later.
REQ-009 SHALL have ports ld_valid  input  1 and ld_data  input  XLEN  late load-data return.
REQ-010 SHALL have ports rs_addr  input  NRP*5, rs_used  input  NRP, rf_rdata  input  NRP*XLEN  raw register-file reads.
REQ-011 SHALL have port rs_data  output  NRP*XLEN  forwarded operand per read port.
REQ-012 SHALL have ports rf_we (1), rf_waddr (5), rf_wdata (XLEN), all outputs, register-file write port.
REQ-013 SHALL have port occupancy  output  4  count of valid entries.

Function
REQ-014 SHALL hold DEPTH entries {valid, we, rd, data, rdy}; stage 0 youngest, stage DEPTH-1 oldest.
REQ-015 SHALL define hold = valid && !rdy in stage DEPTH-1; shift = !hold.
REQ-016 On shift, every entry SHALL move one stage older; stage 0 loads the accepted issue or a bubble (valid=0).
REQ-017 On !shift, all entries SHALL hold position; no bubble inserted.
REQ-018 issue_ready SHALL equal shift && !hazard, combinationally.
REQ-019 Match for port i SHALL require rs_used[i], entry valid, we=1, rd==rs_addr[i], rd!=0.
REQ-020 Youngest matching entry SHALL win; hazard asserts when it has rdy=0 for any port.
REQ-021 rs_data[i] SHALL be data of winning entry if rdy=1, else rf_rdata[i]; x0 always reads rf_rdata.
REQ-022 At most one entry SHALL have rdy=0; issue with issue_data_rdy=0 SHALL be refused (issue_ready=0) while one is pending.
REQ-023 ld_valid SHALL write ld_data into the pending entry and set rdy=1, at its post-shift position if shifting that cycle; ld_valid with no pending entry is ignored.
REQ-024 ld_valid SHALL NOT forward combinationally in the same cycle; data is visible from next cycle.
REQ-025 rf_we SHALL equal shift && stage DEPTH-1 valid && we && rd!=0; rf_waddr/rf_wdata from that entry.
REQ-026 Accepted ready entry SHALL reach rf_we exactly DEPTH shift-cycles after acceptance.
REQ-027 occupancy SHALL reflect registered valid count, 0..DEPTH.

Reset
REQ-028 While rst_n=0 at clk edge, all entries SHALL clear to valid=0, rdy=1, data=0.
REQ-029 After reset: rf_we=0, occupancy=0, issue_ready=1, rs_data=rf_rdata.
REQ-030 Reset mid-operation SHALL discard pending load; later ld_valid ignored.

Configuration
REQ-031 Macro RVIBE_WB_FORWARD_EN defined: forwarding per REQ-021.
REQ-032 Macro RVIBE_WB_FORWARD_EN undefined: any match (ready or not) SHALL be a hazard; rs_data=rf_rdata always; issue stalls until matching entry retires.

Verification
REQ-033 DEPTH=2: issue x5=0x11, next cycle read x5 -> rs_data=0x11, issue_ready=1, rf_we x5 two cycles after issue.
REQ-034 Issue x6=0xA then x6=0xB, read x6 -> rs_data=0xB (youngest wins).
REQ-035 Load to x7 (rdy=0), read x7 -> issue_ready=0; ld_valid ld_data=0x55 -> next cycle rs_data=0x55, issue_ready=1.
REQ-036 Pending load reaches stage DEPTH-1 -> shift stops, occupancy constant, rf_we=0 until ld_valid; then retire x7=0x55.
REQ-037 Write x0=0xFF, read x0 -> rs_data=rf_rdata, rf_we=0 at retire.
REQ-038 Macro undefined: issue x5=0x11, read x5 -> stall DEPTH cycles, then issue_ready=1 with rs_data=rf_rdata.
